// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU: single-cycle arithmetic/logic ops with registered flags,
// plus an unsigned shift-add multiplier that takes N cycles behind busy/done.
module alu_seq_nbit #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   mode,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CB_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] res,
  output logic [N-1:0] res_hi,
  output logic         CB_out,
  output logic         zero,
  output logic         neg,
  output logic         ovf,
  output logic         err
);

  localparam logic [3:0] M_ADD = 4'd0;
  localparam logic [3:0] M_SUB = 4'd1;
  localparam logic [3:0] M_AND = 4'd2;
  localparam logic [3:0] M_OR  = 4'd3;
  localparam logic [3:0] M_XOR = 4'd4;
  localparam logic [3:0] M_NOT = 4'd5;
  localparam logic [3:0] M_INC = 4'd6;
  localparam logic [3:0] M_DEC = 4'd7;
  localparam logic [3:0] M_MUL = 4'd8;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q;
  logic             busy_q, done_q, co_q, zero_q, neg_q, ovf_q, err_q;
  logic [N-1:0]     res_q, res_hi_q;
  logic [2*N-1:0]   acc_q, mcand_q;
  logic [N-1:0]     mplier_q;
  logic [CW-1:0]    cnt_q;

  logic [N:0]       wide_d;
  logic [N-1:0]     op_res_d;
  logic             op_co_d, op_ovf_d, op_err_d;
  logic [2*N-1:0]   acc_d;

  always_comb begin
    wide_d   = '0;
    op_res_d = '0;
    op_co_d  = 1'b0;
    op_ovf_d = 1'b0;
    op_err_d = 1'b0;
    case (mode)
      M_ADD: begin
        wide_d   = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, CB_in};
        op_res_d = wide_d[N-1:0];
        op_co_d  = wide_d[N];
        op_ovf_d = (A[N-1] == B[N-1]) && (wide_d[N-1] != A[N-1]);
      end
      M_SUB: begin
        wide_d   = {1'b0, A} - {1'b0, B} - {{N{1'b0}}, CB_in};
        op_res_d = wide_d[N-1:0];
        op_co_d  = wide_d[N];
        op_ovf_d = (A[N-1] != B[N-1]) && (wide_d[N-1] != A[N-1]);
      end
      M_AND: op_res_d = A & B;
      M_OR:  op_res_d = A | B;
      M_XOR: op_res_d = A ^ B;
      M_NOT: op_res_d = ~A;
      M_INC: begin
        wide_d   = {1'b0, A} + {{N{1'b0}}, 1'b1};
        op_res_d = wide_d[N-1:0];
        op_co_d  = wide_d[N];
        op_ovf_d = !A[N-1] && wide_d[N-1];
      end
      M_DEC: begin
        wide_d   = {1'b0, A} - {{N{1'b0}}, 1'b1};
        op_res_d = wide_d[N-1:0];
        op_co_d  = (A == '0);
        op_ovf_d = A[N-1] && !wide_d[N-1];
      end
      M_MUL: op_err_d = 1'b0;
      default: op_err_d = 1'b1;
    endcase
  end

  // Partial product after folding in the current multiplier bit.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      co_q     <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (mode == M_MUL) begin
              mcand_q  <= {{N{1'b0}}, A};
              mplier_q <= B;
              acc_q    <= '0;
              cnt_q    <= CW'(N-1);
              busy_q   <= 1'b1;
              state_q  <= S_MUL;
            end else begin
              res_q    <= op_res_d;
              res_hi_q <= '0;
              co_q     <= op_co_d;
              zero_q   <= (op_res_d == '0);
              neg_q    <= op_res_d[N-1];
              ovf_q    <= op_ovf_d;
              err_q    <= op_err_d;
              done_q   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == '0) begin
            res_q    <= acc_d[N-1:0];
            res_hi_q <= acc_d[2*N-1:N];
            co_q     <= 1'b0;
            zero_q   <= (acc_d == '0);
            neg_q    <= acc_d[N-1];
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign res    = res_q;
  assign res_hi = res_hi_q;
  assign CB_out = co_q;
  assign zero   = zero_q;
  assign neg    = neg_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Bench for alu_seq_nbit: arithmetic reference model compared every cycle,
// directed literal checks, then randomized traffic with occasional resets.
module tb_alu_seq_nbit;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, start, CB_in;
  logic [3:0]   mode;
  logic [N-1:0] A, B;
  logic         busy, done, CB_out, zero, neg, ovf, err;
  logic [N-1:0] res, res_hi;

  int tests = 0;
  int fails = 0;

  alu_seq_nbit #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .A(A), .B(B),
    .CB_in(CB_in), .busy(busy), .done(done), .res(res), .res_hi(res_hi),
    .CB_out(CB_out), .zero(zero), .neg(neg), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: outputs computed from plain integer arithmetic.
  logic [N-1:0] e_res, e_hi;
  logic         e_co, e_zero, e_neg, e_ovf, e_err, e_done, e_busy;
  logic         mvalid = 1'b0;
  int           busy_left = 0;
  longint       m_a, m_b;

  always @(posedge clk) begin
    longint full, ua, ub, c, sa, sb, r, s, p;
    full = longint'(1) << N;
    if (rst) begin
      e_res = '0; e_hi = '0; e_co = 0; e_zero = 0; e_neg = 0;
      e_ovf = 0; e_err = 0; e_done = 0; busy_left = 0;
    end else begin
      e_done = 0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          p = m_a * m_b;
          e_res = N'(p); e_hi = N'(p >> N);
          e_co = 0; e_ovf = 0; e_err = 0;
          e_zero = (p == 0); e_neg = e_res[N-1]; e_done = 1;
        end
      end else if (start) begin
        if (mode == 4'd8) begin
          m_a = longint'(A); m_b = longint'(B); busy_left = N;
        end else begin
          ua = longint'(A); ub = longint'(B); c = longint'(CB_in);
          sa = A[N-1] ? ua - full : ua;
          sb = B[N-1] ? ub - full : ub;
          r = 0; s = 0; e_co = 0; e_err = 0;
          case (mode)
            4'd0: begin r = ua + ub + c; e_co = (r >= full); s = sa + sb + c; end
            4'd1: begin r = ua - ub - c; e_co = (ua < ub + c); s = sa - sb - c; end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = ~ua;
            4'd6: begin r = ua + 1; e_co = (r >= full); s = sa + 1; end
            4'd7: begin r = ua - 1; e_co = (ua == 0); s = sa - 1; end
            default: e_err = 1;
          endcase
          e_ovf = (s > (full/2 - 1)) || (s < -(full/2));
          e_res = N'(r & (full - 1));
          e_hi = '0;
          e_zero = (e_res == '0);
          e_neg = e_res[N-1];
          e_done = 1;
        end
      end
    end
    e_busy = (busy_left > 0);
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("cyc_done", done, e_done);
      chk("cyc_busy", busy, e_busy);
      chk("cyc_res", res, e_res);
      chk("cyc_res_hi", res_hi, e_hi);
      chk("cyc_cbout", CB_out, e_co);
      chk("cyc_zero", zero, e_zero);
      chk("cyc_neg", neg, e_neg);
      chk("cyc_ovf", ovf, e_ovf);
      chk("cyc_err", err, e_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] m, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic c);
    start = 1'b1; mode = m; A = a; B = b; CB_in = c;
  endtask

  initial begin
    int nb;
    rst = 1'b1; start = 1'b1; mode = 4'd0; A = 8'h12; B = 8'h34; CB_in = 1'b0;
    step(); step();
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res", res, 8'h00);
    rst = 1'b0; start = 1'b0;
    step();

    issue(4'd0, 8'hFF, 8'h01, 1'b0); step();
    chk("add_done", done, 1'b1);
    chk("add_res", res, 8'h00);
    chk("add_co", CB_out, 1'b1);
    chk("add_zero", zero, 1'b1);
    chk("add_ovf", ovf, 1'b0);
    chk("model_add_res", e_res, 8'h00);
    issue(4'd1, 8'h80, 8'h01, 1'b0); step();
    chk("sub_done", done, 1'b1);
    chk("sub_res", res, 8'h7F);
    chk("sub_co", CB_out, 1'b0);
    chk("sub_ovf", ovf, 1'b1);
    chk("sub_neg", neg, 1'b0);
    chk("model_sub_ovf", e_ovf, 1'b1);
    issue(4'd1, 8'h02, 8'h02, 1'b1); step();
    chk("subb_res", res, 8'hFF);
    chk("subb_co", CB_out, 1'b1);
    chk("subb_neg", neg, 1'b1);
    issue(4'd7, 8'h00, 8'h55, 1'b1); step();
    chk("dec_res", res, 8'hFF);
    chk("dec_co", CB_out, 1'b1);
    start = 1'b0; step();

    issue(4'd8, 8'd15, 8'd17, 1'b0); step();
    start = 1'b0; mode = 4'd0;
    nb = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) nb++;
      start = (nb == 3);
      A = 8'h5A; B = 8'hA5;
      step();
    end
    start = 1'b0;
    chk("mul_done", done, 1'b1);
    chk("mul_busy_cycles", nb, 8);
    chk("mul_res", res, 8'hFF);
    chk("mul_res_hi", res_hi, 8'h00);
    chk("model_mul_res", e_res, 8'hFF);
    step();
    chk("mul_done_pulse", done, 1'b0);

    issue(4'd8, 8'hFF, 8'hFF, 1'b0); step();
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) step();
    chk("mul2_done", done, 1'b1);
    chk("mul2_res_hi", res_hi, 8'hFE);
    chk("mul2_res", res, 8'h01);
    step();

    issue(4'd8, 8'd200, 8'd3, 1'b0); step();
    start = 1'b0;
    step(); step(); step();
    chk("abort_busy_pre", busy, 1'b1);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_res", res, 8'h00);
    chk("abort_res_hi", res_hi, 8'h00);
    for (int i = 0; i < 10; i++) step();
    issue(4'd0, 8'd1, 8'd2, 1'b0); step();
    start = 1'b0;
    chk("post_abort_res", res, 8'd3);
    step();

    issue(4'b1010, 8'h77, 8'h66, 1'b1); step();
    chk("rsv_done", done, 1'b1);
    chk("rsv_err", err, 1'b1);
    chk("rsv_res", res, 8'h00);
    chk("rsv_zero", zero, 1'b1);
    issue(4'd2, 8'hF0, 8'h3C, 1'b0); step();
    start = 1'b0;
    chk("and_res", res, 8'h30);
    chk("and_err", err, 1'b0);
    step();

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = $urandom_range(0, 1) == 1;
      mode  = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      A     = N'($urandom);
      B     = N'($urandom);
      CB_in = $urandom_range(0, 1) == 1;
      step();
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 12; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
